// File: rtl/wb_hop_sequencer_if.sv
// Wishbone link between the hop sequencer (master) and the FM generator register slave.
interface wb_hop_sequencer_if;
  logic        cyc;
  logic        stb;
  logic        we;
  logic [1:0]  addr;
  logic [31:0] data;
  logic        ack;
  logic        stall;

  modport master (output cyc, stb, we, addr, data, input ack, stall);
  modport slave  (input cyc, stb, we, addr, data, output ack, stall);
endinterface

// File: rtl/wb_hop_sequencer.sv
// Frequency-hop sequencer: writes table entries to the carrier register, dwells, advances, wraps.
// IDLE wait for enable | FETCH load word | REQ stb out | ACK await ack | DWELL hold | ERR bus timeout
module wb_hop_sequencer #(
  parameter int         TABLE_AW     = 4,
  parameter int         DWELL_WIDTH  = 24,
  parameter int         TIMEOUT      = 16,
  parameter logic [1:0] CARRIER_ADDR = 2'd0
) (
  input  logic                   i_clk,
  input  logic                   i_reset_n,
  input  logic                   i_enable,
  input  logic [TABLE_AW:0]      i_num_hops,
  input  logic [DWELL_WIDTH-1:0] i_dwell,
  input  logic                   i_tbl_we,
  input  logic [TABLE_AW-1:0]    i_tbl_addr,
  input  logic [31:0]            i_tbl_data,
  wb_hop_sequencer_if.master     wb,
  output logic                   o_hop_strobe,
  output logic [TABLE_AW-1:0]    o_hop_index,
  output logic                   o_busy,
  output logic                   o_err
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0]          TMO_LOAD = TW'(TIMEOUT - 1);
  localparam logic [TW-1:0]          TMO_ONE  = TW'(1);
  localparam logic [TABLE_AW:0]      HOPS_ONE = (TABLE_AW + 1)'(1);
  localparam logic [TABLE_AW-1:0]    IDX_ONE  = TABLE_AW'(1);
  localparam logic [DWELL_WIDTH-1:0] DW_ONE   = DWELL_WIDTH'(1);

  typedef enum logic [2:0] {IDLE, FETCH, REQ, ACK, DWELL, ERR} state_t;

  state_t                  state;
  logic [31:0]             tbl [2**TABLE_AW];
  logic [TABLE_AW-1:0]     idx;
  logic [TABLE_AW-1:0]     idx_next;
  logic [TABLE_AW:0]       hops_eff;
  logic [DWELL_WIDTH-1:0]  dwell_cnt;
  logic [TW-1:0]           tmo_cnt;
  logic                    cyc_r;
  logic                    stb_r;
  logic [31:0]             data_r;
  logic                    hop_done;

  assign wb.cyc  = cyc_r;
  assign wb.stb  = stb_r;
  assign wb.we   = cyc_r;
  assign wb.addr = CARRIER_ADDR;
  assign wb.data = data_r;
  assign o_busy  = (state != IDLE);

  // Hop count is sampled here at advance time, so a shrink below the current index wraps to 0.
  always_comb begin
    hops_eff = (i_num_hops == '0) ? HOPS_ONE : i_num_hops;
    idx_next = ({1'b0, idx} >= (hops_eff - HOPS_ONE)) ? '0 : idx + IDX_ONE;
    hop_done = wb.ack && (((state == REQ) && !wb.stall) || (state == ACK));
  end

  always_ff @(posedge i_clk) begin
    if (i_tbl_we) tbl[i_tbl_addr] <= i_tbl_data;
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      state        <= IDLE;
      cyc_r        <= 1'b0;
      stb_r        <= 1'b0;
      data_r       <= '0;
      o_hop_strobe <= 1'b0;
      o_hop_index  <= '0;
      o_err        <= 1'b0;
      idx          <= '0;
      dwell_cnt    <= '0;
      tmo_cnt      <= '0;
    end else begin
      o_hop_strobe <= 1'b0;
      case (state)
        IDLE: begin
          if (i_enable) begin
            state <= FETCH;
            idx   <= '0;
            o_err <= 1'b0;
          end
        end
        FETCH: begin
          data_r <= tbl[idx];
          if (!i_enable) begin
            state <= IDLE;
          end else begin
            state   <= REQ;
            cyc_r   <= 1'b1;
            stb_r   <= 1'b1;
            tmo_cnt <= TMO_LOAD;
          end
        end
        REQ, ACK: begin
          // An accepted transfer always runs to ack; enable only matters once it completes.
          if (hop_done) begin
            cyc_r        <= 1'b0;
            stb_r        <= 1'b0;
            o_hop_strobe <= 1'b1;
            o_hop_index  <= idx;
            dwell_cnt    <= i_dwell;
            state        <= i_enable ? DWELL : IDLE;
          end else if (tmo_cnt == '0) begin
            o_err <= 1'b1;
            cyc_r <= 1'b0;
            stb_r <= 1'b0;
            state <= ERR;
          end else begin
            tmo_cnt <= tmo_cnt - TMO_ONE;
            if ((state == REQ) && !wb.stall) begin
              stb_r <= 1'b0;
              state <= ACK;
            end
          end
        end
        DWELL: begin
          if (!i_enable) begin
            state <= IDLE;
          end else if (dwell_cnt == '0) begin
            state <= FETCH;
            idx   <= idx_next;
          end else begin
            dwell_cnt <= dwell_cnt - DW_ONE;
          end
        end
        ERR: begin
          if (!i_enable) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
